// File: rtl/ram_bank.sv
// Single-port data RAM with byte-enable writes, 1-cycle registered read and a
// sequential clear engine that zeroes every word after reset or on request.
module ram_bank #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 32,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_rsp_zero;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_bad;
    logic [IDX_W-1:0]    w_idx;
    logic                w_clr_we;
    logic                w_rd_en;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [NB-1:0]       w_lane_we;
    logic [DATA_W-1:0]   w_rd_word;

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CLEAR);

    assign w_accept = req_valid & req_ready & ~rst;
    assign w_idx    = req_addr[OFF+IDX_W-1:OFF];

    generate
        if (OFF > 0) begin : g_misaligned
            assign w_misaligned = |req_addr[OFF-1:0];
        end else begin : g_aligned
            assign w_misaligned = 1'b0;
        end

        if (OFF + IDX_W < ADDR_W) begin : g_range
            assign w_out_of_range = |req_addr[ADDR_W-1:OFF+IDX_W];
        end else begin : g_full_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_bad    = w_misaligned | w_out_of_range;
    assign w_clr_we = (r_state == ST_CLEAR) & ~rst;
    assign w_rd_en  = w_accept & ~req_we & ~w_bad;
    assign w_wr_idx = w_clr_we ? r_cnt : w_idx;

    // One 8-bit wide array per byte lane so byte enables map onto plain
    // per-lane write enables; the clear engine drives all lanes at once.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd;

            assign w_lane_we[gi] = w_clr_we |
                                   (w_accept & req_we & ~w_bad & req_be[gi]);

            always_ff @(posedge clk) begin
                if (w_lane_we[gi]) begin
                    r_mem[w_wr_idx] <= w_clr_we ? 8'h00 : req_wdata[gi*8 +: 8];
                end
                if (w_rd_en) begin
                    r_rd <= r_mem[w_idx];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_rd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_zero  <= 1'b1;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err  <= w_bad;
                r_rsp_zero <= req_we | w_bad;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // The lane read registers only load on good reads, so masking them with
    // r_rsp_zero keeps the last response visible while rsp_valid is low.
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_zero ? '0 : w_rd_word;

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised single-port data RAM; successor to the fixed 256x32 data memory.
- Adds configurable width/depth, byte-enable writes, a registered 1-cycle read with valid/ready handshake, address-error detection, and a sequential clear engine that replaces the non-synthesisable whole-array reset.
- Sits between the core's load/store unit and the memory bus. Also serves as instruction/data scratchpad.

Parameters:
- DATA_W, 32, data width in bits; a multiple of 8, minimum 8.
- DEPTH, 256, number of words; a power of two, minimum 2.
- ADDR_W, 32, byte-address width.
- CLR_ON_RST, 1, when 1 the clear engine runs automatically after reset; when 0 memory contents are undefined after reset.
- Derived, not overridable:
  - NB = DATA_W/8.
  - OFF = log2(NB).
  - IDX_W = log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  NB  byte enables; bit i controls byte i (bits [8i+7:8i]).
- rsp_valid  out  1  one-cycle pulse marking the response.
- rsp_rdata  out  DATA_W  read data; held between responses.
- rsp_err  out  1  the response's request had a bad address.
- clr_req  in  1  pulse that starts a software clear.
- busy  out  1  clear engine active.

Behaviour:

Reset (rst=1 at an edge):
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Clear counter = 0.
- FSM state is CLEAR if CLR_ON_RST=1, otherwise IDLE.
- Reset asserted during a clear restarts the clear from index 0.

FSM states: IDLE, CLEAR.

CLEAR state:
- busy=1, req_ready=0.
- Each cycle writes 0 to word[cnt], then cnt += 1.
- After writing word DEPTH-1: go to IDLE, cnt = 0.
- A full clear takes exactly DEPTH cycles.
- clr_req is ignored while in CLEAR.

IDLE state:
- busy=0, req_ready=1.
- clr_req=1 → CLEAR on the next cycle. When clr_req and req_valid are both 1 in the same cycle, the request is still served and the clear starts on the next cycle.

Request acceptance and addressing:
- A request is accepted when req_valid & req_ready.
- Word index = req_addr[OFF+IDX_W-1:OFF].
- Bad address: req_addr[OFF-1:0] != 0 (misaligned), or any bit of req_addr[ADDR_W-1:OFF+IDX_W] != 0 (out of range).

Accepted write:
- Good address: for each i with req_be[i]=1, byte i of the word ← req_wdata byte i. Bytes with req_be[i]=0 are unchanged. req_be = 0 writes nothing but still produces a response.
- Bad address: no write.
- Response on the next cycle: rsp_valid=1, rsp_err = bad, rsp_rdata = 0.

Accepted read:
- Next cycle: rsp_valid=1.
- rsp_rdata = word[index], or 0 if the address is bad.
- rsp_err = bad.

Timing and ordering:
- Latency is exactly 1 cycle. One request per cycle is sustained with no bubbles.
- The response is not back-pressured.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data.
- A single access is either a read or a write, so same-cycle read/write collision does not arise.
- rsp_rdata and rsp_err hold their values when rsp_valid=0. They are updated only on a response.
- Responses during a clear: none; rsp_valid=0 throughout. A response owed for the request accepted in the cycle before the clear starts is still issued.

Test Plan:
1. Reset with CLR_ON_RST=1, DEPTH=256:
   - busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1.
   - Read at 0x3FC → rsp_valid one cycle later, rsp_rdata=0x00000000, rsp_err=0.
2. Byte-enable write:
   - Write 0x11223344 be=0xF at 0x10, then 0xAABBCCDD be=0x5 at 0x10.
   - Read 0x10 → 0x11BB33DD.
3. Back-to-back traffic:
   - Writes to 0x0, 0x4, 0x8 in consecutive cycles, then reads of the same addresses in consecutive cycles.
   - rsp_valid stays high for 6 cycles; read data matches the written data.
   - Read of 0x4 immediately after its write returns the new value.
4. Errors:
   - Read 0x2 → rsp_err=1, rdata=0.
   - Write 0x400 with DEPTH=256 → rsp_err=1, memory unchanged.
   - A subsequent read of 0x0 returns its prior value.
5. Soft clear: fill words 0..3, pulse clr_req together with a read of 0x4:
   - The read response is issued.
   - busy=1 for 256 cycles, then all 4 words read 0.
6. Reset mid-clear:
   - Assert rst at clear cycle 100 → the clear restarts and busy lasts 256 cycles after rst deasserts.
   - Parameter sweep DATA_W=64, DEPTH=16 → OFF=3; address 0x78 maps to index 15; address 0x80 → rsp_err=1.
